// File: rtl/skip_subtractor32_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined 32-bit borrow-skip subtractor.
interface skip_subtractor32_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bo;
  logic        ovf;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo, ovf
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo, ovf
  );
endinterface

// File: rtl/skip_subtractor32_pipe.sv
// Four-stage 32-bit borrow-skip subtractor: each stage resolves one byte (two 4-bit skip groups)
// and forwards the remaining operand bytes, the finished difference bytes and the borrow.
module skip_subtractor32_pipe (
  input logic                      clk,
  input logic                      rst_n,
  skip_subtractor32_pipe_if.slave  bus
);

  // Returns {borrow_out, diff[7:0]}; a group whose bits all propagate passes its borrow-in.
  function automatic logic [8:0] sub8(input logic [7:0] x, input logic [7:0] y,
                                      input logic br_in);
    logic [7:0] df;
    logic [3:0] p;
    logic       br;
    logic       gin;
    br = br_in;
    df = '0;
    for (int g = 0; g < 2; g++) begin
      gin = br;
      p   = ~(x[4*g +: 4] ^ y[4*g +: 4]);
      for (int i = 0; i < 4; i++) begin
        df[4*g+i] = x[4*g+i] ^ y[4*g+i] ^ br;
        br        = (~x[4*g+i] & y[4*g+i]) | (~(x[4*g+i] ^ y[4*g+i]) & br);
      end
      if (&p) br = gin;
    end
    return {br, df};
  endfunction

  logic        v0_q, v1_q, v2_q, v3_q;
  logic        acc0, acc1, acc2, acc3;
  logic        xfer;

  logic [23:0] a_rem0_q, b_rem0_q;
  logic [7:0]  d0_q;
  logic        br0_q;
  logic [15:0] a_rem1_q, b_rem1_q;
  logic [15:0] d1_q;
  logic        br1_q;
  logic [7:0]  a_rem2_q, b_rem2_q;
  logic [23:0] d2_q;
  logic        br2_q;
  logic [31:0] d3_q;
  logic        bo3_q;
  logic        ovf3_q;

  logic [8:0]  s0_res, s1_res, s2_res, s3_res;
  logic        ovf3_d;

  assign acc3 = !v3_q || bus.out_ready;
  assign acc2 = !v2_q || acc3;
  assign acc1 = !v1_q || acc2;
  assign acc0 = !v0_q || acc1;
  assign xfer = bus.in_valid && acc0;

  assign s0_res = sub8(bus.a[7:0], bus.b[7:0], bus.bi);
  assign s1_res = sub8(a_rem0_q[7:0], b_rem0_q[7:0], br0_q);
  assign s2_res = sub8(a_rem1_q[7:0], b_rem1_q[7:0], br1_q);
  assign s3_res = sub8(a_rem2_q, b_rem2_q, br2_q);
  // a_rem2_q[7]/b_rem2_q[7] are the original operand sign bits.
  assign ovf3_d = (a_rem2_q[7] != b_rem2_q[7]) && (s3_res[7] != a_rem2_q[7]);

  // Data loads only with a valid op so the outputs stay 0 until the first result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      a_rem0_q <= '0;
      b_rem0_q <= '0;
      d0_q     <= '0;
      br0_q    <= 1'b0;
      a_rem1_q <= '0;
      b_rem1_q <= '0;
      d1_q     <= '0;
      br1_q    <= 1'b0;
      a_rem2_q <= '0;
      b_rem2_q <= '0;
      d2_q     <= '0;
      br2_q    <= 1'b0;
      d3_q     <= '0;
      bo3_q    <= 1'b0;
      ovf3_q   <= 1'b0;
    end else begin
      if (acc0) v0_q <= xfer;
      if (xfer) begin
        a_rem0_q <= bus.a[31:8];
        b_rem0_q <= bus.b[31:8];
        d0_q     <= s0_res[7:0];
        br0_q    <= s0_res[8];
      end
      if (acc1) v1_q <= v0_q;
      if (acc1 && v0_q) begin
        a_rem1_q <= a_rem0_q[23:8];
        b_rem1_q <= b_rem0_q[23:8];
        d1_q     <= {s1_res[7:0], d0_q};
        br1_q    <= s1_res[8];
      end
      if (acc2) v2_q <= v1_q;
      if (acc2 && v1_q) begin
        a_rem2_q <= a_rem1_q[15:8];
        b_rem2_q <= b_rem1_q[15:8];
        d2_q     <= {s2_res[7:0], d1_q};
        br2_q    <= s2_res[8];
      end
      if (acc3) v3_q <= v2_q;
      if (acc3 && v2_q) begin
        d3_q   <= {s3_res[7:0], d2_q};
        bo3_q  <= s3_res[8];
        ovf3_q <= ovf3_d;
      end
    end
  end

  assign bus.in_ready  = acc0;
  assign bus.out_valid = v3_q;
  assign bus.d         = d3_q;
  assign bus.bo        = bo3_q;
  assign bus.ovf       = ovf3_q;

endmodule

// File: doc/skip_subtractor32_pipe.md
# skip_subtractor32_pipe

Pipelined 32-bit borrow-skip subtractor with valid/ready handshakes. It computes `d = a - b - bi` using 4-bit borrow-skip groups, two groups per pipeline stage, across four register stages. It is the subtraction counterpart of the team's 32-bit carry-skip adder and sits on the datapath wherever a registered, flow-controlled difference is needed. It accepts one operation per cycle and supports downstream backpressure.

## Interface
- No parameters; width fixed at 32, group size 4, 4 stages.
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready` at rising edge.
- `a`  in  32  minuend (unsigned or two's complement).
- `b`  in  32  subtrahend.
- `bi`  in  1  borrow in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid && out_ready`.
- `d`  out  32  difference, `(a - b - bi) mod 2^32`.
- `bo`  out  1  borrow out; 1 iff `a < b + bi` (unsigned).
- `ovf`  out  1  signed overflow: `(a[31] != b[31]) && (d[31] != a[31])`.

## Operation
- Per bit: difference `a_i ^ b_i ^ br_i`; borrow `(~a_i & b_i) | (~(a_i ^ b_i) & br_i)`.
- Group propagate: `p_i = ~(a_i ^ b_i)`. Group skip: when all four `p_i` of a group are 1, the group borrow-out equals its borrow-in (mux select). Otherwise it equals the rippled borrow.
- Stage k (k=0..3) computes bits `[8k+7:8k]` (groups 2k, 2k+1) from the borrow registered by stage k-1. Stage 0 uses `bi`.
- Operand skew: unprocessed operand bytes travel forward in each stage's registers. Completed difference bytes also accumulate forward. Stage 3 registers drive `d`, `bo`, `ovf`. `ovf` uses `a[31]` and `b[31]` carried to stage 3.
- Each stage k has `v_k`. A stage advances when `acc_k = !v_k || acc_{k+1}`, with `acc_4 = out_ready`.
- `in_ready = acc_0`, a combinational function of the valid bits and `out_ready` only.
- On advance, stage k loads stage k-1 data, and `v_k <= v_{k-1}` (`v_{-1}` = input transfer). When the stage holds, data and valid are unchanged.
- `out_valid = v_3`. Held results remain stable until consumed.
- Data registers of empty stages are don't-care internally. Outputs `d`, `bo`, `ovf` must still read 0 whenever `out_valid` = 0 after reset, until the first result arrives. After the first result, they hold their last value when `out_valid` drops.
- No combinational path from `in_valid`/`a`/`b` to any output.

## Timing
- Reset (`rst_n` low, asynchronous): all `v_k` = 0, `out_valid` = 0, `d` = 0, `bo` = 0, `ovf` = 0, all stage data cleared. `in_ready` = 1 while `rst_n` is low and on the first cycle after release.
- Reset mid-operation: all in-flight operations are discarded immediately. No stale result may appear after release.
- Latency, no stalls: operation accepted at edge t appears with `out_valid` = 1 immediately after edge t+3.
- Throughput: one operation per cycle while `out_ready` = 1.
- Backpressure with `out_ready` = 0: the pipeline fills. Bubbles collapse: an empty stage accepts even while a later stage stalls. `in_ready` falls only when all four stages are valid. At most 4 operations are buffered.
- Simultaneous output consume and input accept on a full pipe: allowed in the same cycle (`in_ready` = 1 via the `out_ready` chain).
- Results leave in strict acceptance order. No drop, no duplication.

## Test plan
- `a=5, b=3, bi=0`, single op, `out_ready=1` → `d=0x00000002, bo=0, ovf=0`, `out_valid` high exactly after the 4th edge counted from acceptance, for one cycle.
- `a=0, b=1, bi=0` → `d=0xFFFFFFFF, bo=1, ovf=0`. Then `a=0x80000000, b=1` → `d=0x7FFFFFFF, bo=0, ovf=1`.
- Full-skip path: `a=b=0xA5A5A5A5, bi=1` → `d=0xFFFFFFFF, bo=1`. With `bi=0` → `d=0, bo=0`.
- Backpressure: stream 6 ops `a=i+10, b=i` (i=0..5) with `out_ready=0` for 8 cycles, then 1. Required behaviour:
  - `in_ready` drops after 4 accepted.
  - All 6 results (`d=10`) emerge in order, each `d`/`bo`/`ovf` stable while stalled.
  - Random `out_ready` over 10k random ops matches a reference model.
- Reset mid-flight: 3 ops in pipe, drive `rst_n` low asynchronously (not on an edge) → `out_valid`, `d`, `bo`, `ovf` go 0 immediately. After release, no output until new input; `in_ready=1`.
